fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Serial transmit stage that drains the byte FIFO and emits each entry as an asynchronous UART frame on a single line. It sits directly downstream of the FIFO read port. It pops one entry at a time through the FIFO's `rd_en`/`rd_val` handshake and shifts it out LSB-first, with optional even parity and a configurable stop length. It is the only reader of that FIFO.

## Interface
- `DATA_WIDTH`, 8: width of one FIFO entry and of the frame payload.
- `CLKS_PER_BIT`, 16: clk cycles per serial bit; must be ≥ 2.
- `PARITY_EN`, 0: 1 inserts an even-parity bit after the data bits.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

Ports:
- `clk`  in  1: clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: permission to start new frames.
- `fifo_rd_val`  in  1: FIFO holds at least one entry.
- `fifo_rd_data`  in  DATA_WIDTH: FIFO read data; registered, valid the cycle after a pop.
- `fifo_rd_en`  out  1: pop request; one-cycle pulse.
- `tx`  out  1: serial line; idle high.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- **IDLE:** `tx`=1. Goes to POP when `enable & fifo_rd_val`; otherwise stays.
- **POP:** `fifo_rd_en`=1 for exactly this cycle, decoded from registered state (`fifo_rd_en = (state==POP)`).
  - If `fifo_rd_val`=0 here, no pop occurs and the FSM returns to IDLE with no frame.
  - Otherwise it goes to LOAD.
- **LOAD:** captures `fifo_rd_data` into the shift register and computes parity as the XOR of all data bits. Goes to START.
- **START:** `tx`=0 for CLKS_PER_BIT cycles.
- **DATA:** `tx`=`shift[0]`. Shifts right every CLKS_PER_BIT cycles, DATA_WIDTH bits total.
- **PARITY:** entered only if PARITY_EN=1. `tx`=parity for CLKS_PER_BIT cycles.
- **STOP:** `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles, then IDLE.
- Baud counter:
  - width `$clog2(CLKS_PER_BIT)`.
  - cleared on every state entry.
  - the bit ends when count == CLKS_PER_BIT−1.
- Bit counter: width `$clog2(DATA_WIDTH)+1`, counts DATA bits and stop bits.
- `enable` is sampled only in IDLE. Deasserting it mid-frame lets the current frame complete; no further pop follows.
- `fifo_rd_val` is ignored outside IDLE and POP.
- Reset mid-frame:
  - next cycle: state=IDLE, `tx`=1, `fifo_rd_en`=0, counters 0.
  - the partially sent byte is dropped.
  - a byte popped but not yet loaded is lost.
- `tx` is a registered output, with no combinational path from any input.

## Timing
- Reset values: `tx`=1, `busy`=0, `fifo_rd_en`=0, state=IDLE.
- Cycle n: IDLE sees `enable & fifo_rd_val`.
- Cycle n+1: POP, `fifo_rd_en`=1.
- Cycle n+2: LOAD.
- Cycle n+3: first cycle with `tx`=0.
- Frame length is (1 + DATA_WIDTH + PARITY_EN + STOP_BITS)×CLKS_PER_BIT cycles.
- Back-to-back frames: after the last STOP cycle, `tx` stays 1 for exactly 3 extra cycles (IDLE, POP, LOAD) before the next START.
- `busy` rises at n+1 and falls in the cycle after the last STOP cycle.

## Structure
- Package `fifo_uart_pkg` holds:
  - the state enum typedef `uart_tx_state_t`.
  - `UART_IDLE_LEVEL`=1'b1, `UART_START_LEVEL`=1'b0.
- Sub-module `baud_tick`:
  - parameter CLKS_PER_BIT.
  - inputs `clk`, `reset`, `clear`.
  - output `tick` is high on the last cycle of each bit period.
- All remaining logic lives in `fifo_uart_tx`.

## Test plan
(CLKS_PER_BIT=4, DATA_WIDTH=8 unless stated.)
- **Reset held 3 cycles** with `fifo_rd_val`=1 → `tx`=1, `busy`=0, `fifo_rd_en`=0 throughout.
- **Single byte 0xA5** in the FIFO, `enable`=1 → `fifo_rd_en` high for exactly 1 cycle. `tx` bits are 0,1,0,1,0,0,1,0,1,1, each 4 cycles, starting 3 cycles after `rd_val` is seen. `busy` is high for 42 cycles.
- **PARITY_EN=1, byte 0x07** → parity bit 1. **Byte 0x03** → parity bit 0. Frame is 44 cycles.
- **FIFO holds 0x00, 0xFF; STOP_BITS=2** → two frames. `tx` is high for exactly 8+3 cycles between the last data bit of frame 1 and the start bit of frame 2. Two pops total.
- **Reset asserted during data bit 3 of 0x5A** → `tx`=1 the next cycle. The following frame carries the next FIFO entry complete from its start bit.
- **`enable`=0 with FIFO non-empty** → no pop for 20 cycles.
- **`enable` dropped mid-frame** → the frame completes; no second pop.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and line levels for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StPop    = 3'd1,
        StLoad   = 3'd2,
        StStart  = 3'd3,
        StData   = 3'd4,
        StParity = 3'd5,
        StStop   = 3'd6
    } uart_tx_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: tick is high on the last clk cycle of each serial bit.
module baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q, count_d;

    assign tick = (count_q == LAST);

    always_comb begin
        count_d = count_q + CW'(1);
        if (clear || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the upstream FIFO and shifts each out as an LSB-first UART frame
// with optional even parity and one or two stop bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_rd_val,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy
);

    localparam int unsigned BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    uart_tx_state_t        state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  tick;
    logic                  state_change;

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .reset(reset),
        .clear(state_change),
        .tick (tick)
    );

    assign state_change = (state_d != state_q);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (enable && fifo_rd_val) begin
                    state_d = StPop;
                end
            end
            StPop: begin
                state_d = fifo_rd_val ? StLoad : StIdle;
            end
            StLoad: begin
                shift_d  = fifo_rd_data;
                parity_d = ^fifo_rd_data;
                state_d  = StStart;
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        state_d = (PARITY_EN != 0) ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d = StIdle;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (state_d != state_q) begin
            bit_cnt_d = '0;
        end
    end

    // tx is decoded from the next state so the registered line changes with the state.
    always_comb begin
        tx_d = UART_IDLE_LEVEL;
        case (state_d)
            StStart:  tx_d = UART_START_LEVEL;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = parity_d;
            default:  tx_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= UART_IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end

    assign fifo_rd_en = (state_q == StPop);
    assign busy       = (state_q != StIdle);
    assign tx         = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Two transmitters (no parity / 1 stop, even parity / 2 stop) fed from queue-based FIFO
// models and checked cycle by cycle against a frame-level waveform model.
module tb_fifo_uart_tx;

    localparam int CPB  = 4;
    localparam int DW   = 8;
    localparam int MAXC = 1024;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic       val0   = 1'b0;
    logic       val1   = 1'b0;
    logic [7:0] rd0    = 8'h00;
    logic [7:0] rd1    = 8'h00;
    logic       rden0, rden1, tx0, tx1, busy0, busy1;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .PARITY_EN   (0),
        .STOP_BITS   (1)
    ) dut0 (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .fifo_rd_val (val0),
        .fifo_rd_data(rd0),
        .fifo_rd_en  (rden0),
        .tx          (tx0),
        .busy        (busy0)
    );

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .PARITY_EN   (1),
        .STOP_BITS   (2)
    ) dut1 (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .fifo_rd_val (val1),
        .fifo_rd_data(rd1),
        .fifo_rd_en  (rden1),
        .tx          (tx1),
        .busy        (busy1)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] fq0[$];
    logic [7:0] fq1[$];
    logic [7:0] bytes_q[$];
    int         pops[2];
    bit         cap_on = 1'b0;
    int         cap_n  = 0;
    int         first_bad;
    logic       ctx[2][MAXC];
    logic       cbusy[2][MAXC];
    logic       crd[2][MAXC];
    logic       etx[2][MAXC];
    logic       ebusy[2][MAXC];
    logic       erd[2][MAXC];

    // One clock: FIFO model reacts at the falling edge, outputs are sampled 1 after the rise.
    task automatic step();
        @(negedge clk);
        val0 = (fq0.size() != 0);
        val1 = (fq1.size() != 0);
        if (rden0 && fq0.size() != 0) begin
            rd0 = fq0.pop_front();
            pops[0]++;
        end
        if (rden1 && fq1.size() != 0) begin
            rd1 = fq1.pop_front();
            pops[1]++;
        end
        @(posedge clk);
        #1;
        if (cap_on && cap_n < MAXC) begin
            ctx[0][cap_n]   = tx0;
            ctx[1][cap_n]   = tx1;
            cbusy[0][cap_n] = busy0;
            cbusy[1][cap_n] = busy1;
            crd[0][cap_n]   = rden0;
            crd[1][cap_n]   = rden1;
            cap_n++;
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic push_both(input logic [7:0] b);
        fq0.push_back(b);
        fq1.push_back(b);
    endtask

    task automatic start_capture();
        cap_n  = 0;
        cap_on = 1'b1;
    endtask

    task automatic flush();
        cap_on = 1'b0;
        enable = 1'b0;
        reset  = 1'b1;
        fq0.delete();
        fq1.delete();
        steps(2);
        reset = 1'b0;
        step();
    endtask

    function automatic void put(input int d, input int k, input logic t, input logic b,
                                input logic r);
        if (k < MAXC) begin
            etx[d][k]   = t;
            ebusy[d][k] = b;
            erd[d][k]   = r;
        end
    endfunction

    // Expected waveform for dut d; index 0 is the POP cycle of the first byte in bytes_q.
    task automatic build_exp(input int d);
        int   k;
        int   par;
        int   stb;
        logic fb[$];
        k   = 0;
        par = d;
        stb = d + 1;
        for (int i = 0; i < MAXC; i++) put(d, i, 1'b1, 1'b0, 1'b0);
        foreach (bytes_q[i]) begin
            if (i > 0) begin
                put(d, k, 1'b1, 1'b0, 1'b0);
                k++;
            end
            put(d, k, 1'b1, 1'b1, 1'b1);
            k++;
            put(d, k, 1'b1, 1'b1, 1'b0);
            k++;
            fb.delete();
            fb.push_back(1'b0);
            for (int j = 0; j < DW; j++) fb.push_back(((bytes_q[i] >> j) & 8'h01) != 0);
            if (par != 0) fb.push_back(($countones(bytes_q[i]) % 2) == 1);
            for (int j = 0; j < stb; j++) fb.push_back(1'b1);
            foreach (fb[j]) begin
                for (int c = 0; c < CPB; c++) begin
                    put(d, k, fb[j], 1'b1, 1'b0);
                    k++;
                end
            end
        end
    endtask

    function automatic int wave_diff(input int d, input int n);
        int bad;
        bad       = 0;
        first_bad = -1;
        for (int i = 0; i < n; i++) begin
            if (ctx[d][i] !== etx[d][i] || cbusy[d][i] !== ebusy[d][i] ||
                crd[d][i] !== erd[d][i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        return bad;
    endfunction

    task automatic test_reset();
        int nb;
        int p[2];
        p      = pops;
        reset  = 1'b1;
        enable = 1'b1;
        push_both(8'h3C);
        start_capture();
        steps(3);
        cap_on = 1'b0;
        bytes_q.delete();
        for (int d = 0; d < 2; d++) begin
            build_exp(d);
            nb = wave_diff(d, 3);
            checks++;
            if (nb !== 0) begin
                errors++;
                $display("FAIL reset_idle dut%0d: %0d bad slots, first %0d tx=%b busy=%b rd_en=%b, required tx=1 busy=0 rd_en=0",
                         d, nb, first_bad, ctx[d][first_bad], cbusy[d][first_bad],
                         crd[d][first_bad]);
            end
            checks++;
            if (pops[d] - p[d] !== 0) begin
                errors++;
                $display("FAIL reset_no_pop dut%0d: pops=%0d required 0", d, pops[d] - p[d]);
            end
        end
        flush();
    endtask

    task automatic test_single_byte();
        int nb;
        int nbusy;
        int nrd;
        int p[2];
        p      = pops;
        enable = 1'b1;
        push_both(8'hA5);
        start_capture();
        steps(60);
        cap_on = 1'b0;
        bytes_q = '{8'hA5};
        for (int d = 0; d < 2; d++) begin
            build_exp(d);
            nb = wave_diff(d, 60);
            checks++;
            if (nb !== 0) begin
                errors++;
                $display("FAIL single_wave dut%0d: %0d bad slots, first %0d tx=%b busy=%b rd_en=%b, required tx=%b busy=%b rd_en=%b",
                         d, nb, first_bad, ctx[d][first_bad], cbusy[d][first_bad],
                         crd[d][first_bad], etx[d][first_bad], ebusy[d][first_bad],
                         erd[d][first_bad]);
            end
            nbusy = 0;
            nrd   = 0;
            for (int i = 0; i < 60; i++) begin
                if (cbusy[d][i] === 1'b1) nbusy++;
                if (crd[d][i] === 1'b1) nrd++;
            end
            checks++;
            if (nbusy !== 2 + (1 + DW + d + d + 1) * CPB) begin
                errors++;
                $display("FAIL single_busy_len dut%0d: got %0d required %0d", d, nbusy,
                         2 + (1 + DW + d + d + 1) * CPB);
            end
            checks++;
            if (nrd !== 1) begin
                errors++;
                $display("FAIL single_rd_en_pulses dut%0d: got %0d required 1", d, nrd);
            end
            checks++;
            if (pops[d] - p[d] !== 1) begin
                errors++;
                $display("FAIL single_pops dut%0d: got %0d required 1", d, pops[d] - p[d]);
            end
        end
        flush();
    endtask

    task automatic test_parity();
        int nb;
        push_both(8'h07);
        push_both(8'h03);
        enable = 1'b1;
        start_capture();
        steps(120);
        cap_on = 1'b0;
        bytes_q = '{8'h07, 8'h03};
        for (int d = 0; d < 2; d++) begin
            build_exp(d);
            nb = wave_diff(d, 120);
            checks++;
            if (nb !== 0) begin
                errors++;
                $display("FAIL parity_wave dut%0d: %0d bad slots, first %0d tx=%b required %b",
                         d, nb, first_bad, ctx[d][first_bad], etx[d][first_bad]);
            end
        end
        // Frame 1 starts at index 2, frame 2 at 2 + 48 + 3 on the parity/2-stop unit.
        checks++;
        if (ctx[1][2 + 9 * CPB + 1] !== 1'b1) begin
            errors++;
            $display("FAIL parity_bit_07: got %b required 1", ctx[1][2 + 9 * CPB + 1]);
        end
        checks++;
        if (ctx[1][53 + 9 * CPB + 1] !== 1'b0) begin
            errors++;
            $display("FAIL parity_bit_03: got %b required 0", ctx[1][53 + 9 * CPB + 1]);
        end
        flush();
    endtask

    task automatic test_back_to_back();
        int nb;
        int i0;
        int i1;
        int i2;
        int p[2];
        p = pops;
        push_both(8'h00);
        push_both(8'hFF);
        enable = 1'b1;
        start_capture();
        steps(120);
        cap_on = 1'b0;
        bytes_q = '{8'h00, 8'hFF};
        for (int d = 0; d < 2; d++) begin
            build_exp(d);
            nb = wave_diff(d, 120);
            checks++;
            if (nb !== 0) begin
                errors++;
                $display("FAIL b2b_wave dut%0d: %0d bad slots, first %0d tx=%b required %b",
                         d, nb, first_bad, ctx[d][first_bad], etx[d][first_bad]);
            end
            i0 = -1;
            i1 = -1;
            i2 = -1;
            for (int i = 0; i < 120; i++) begin
                if (i0 < 0 && ctx[d][i] === 1'b0) i0 = i;
                else if (i0 >= 0 && i1 < 0 && ctx[d][i] === 1'b1) i1 = i;
                else if (i1 >= 0 && i2 < 0 && ctx[d][i] === 1'b0) i2 = i;
            end
            checks++;
            if (i1 < 0 || i2 < 0 || (i2 - i1) !== (d + 1) * CPB + 3) begin
                errors++;
                $display("FAIL b2b_gap dut%0d: high run %0d required %0d", d, i2 - i1,
                         (d + 1) * CPB + 3);
            end
            checks++;
            if (pops[d] - p[d] !== 2) begin
                errors++;
                $display("FAIL b2b_pops dut%0d: got %0d required 2", d, pops[d] - p[d]);
            end
        end
        flush();
    endtask

    task automatic test_reset_mid_frame();
        int         nb;
        logic [7:0] nxt;
        int         p[2];
        p   = pops;
        nxt = 8'($urandom_range(0, 255));
        push_both(8'h5A);
        push_both(nxt);
        enable = 1'b1;
        start_capture();
        steps(20);
        reset = 1'b1;
        step();
        reset  = 1'b0;
        cap_on = 1'b0;
        bytes_q = '{8'h5A};
        for (int d = 0; d < 2; d++) begin
            build_exp(d);
            nb = wave_diff(d, 20);
            checks++;
            if (nb !== 0) begin
                errors++;
                $display("FAIL midrst_prefix dut%0d: %0d bad slots, first %0d tx=%b required %b",
                         d, nb, first_bad, ctx[d][first_bad], etx[d][first_bad]);
            end
            checks++;
            if ({ctx[d][20], cbusy[d][20], crd[d][20]} !== 3'b100) begin
                errors++;
                $display("FAIL midrst_after dut%0d: tx/busy/rd_en=%b%b%b required 100", d,
                         ctx[d][20], cbusy[d][20], crd[d][20]);
            end
        end
        start_capture();
        steps(60);
        cap_on = 1'b0;
        bytes_q = '{nxt};
        for (int d = 0; d < 2; d++) begin
            build_exp(d);
            nb = wave_diff(d, 60);
            checks++;
            if (nb !== 0) begin
                errors++;
                $display("FAIL midrst_next_frame dut%0d byte %h: %0d bad slots, first %0d tx=%b required %b",
                         d, nxt, nb, first_bad, ctx[d][first_bad], etx[d][first_bad]);
            end
            checks++;
            if (pops[d] - p[d] !== 2) begin
                errors++;
                $display("FAIL midrst_pops dut%0d: got %0d required 2", d, pops[d] - p[d]);
            end
        end
        flush();
    endtask

    task automatic test_enable_low();
        int nb;
        int p[2];
        p      = pops;
        enable = 1'b0;
        push_both(8'($urandom_range(0, 255)));
        start_capture();
        steps(20);
        cap_on = 1'b0;
        bytes_q.delete();
        for (int d = 0; d < 2; d++) begin
            build_exp(d);
            nb = wave_diff(d, 20);
            checks++;
            if (nb !== 0) begin
                errors++;
                $display("FAIL enlow_idle dut%0d: %0d bad slots, first %0d busy=%b rd_en=%b required 0 0",
                         d, nb, first_bad, cbusy[d][first_bad], crd[d][first_bad]);
            end
            checks++;
            if (pops[d] - p[d] !== 0) begin
                errors++;
                $display("FAIL enlow_no_pop dut%0d: got %0d required 0", d, pops[d] - p[d]);
            end
        end
        enable = 1'b1;
        steps(60);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (pops[d] - p[d] !== 1) begin
                errors++;
                $display("FAIL enlow_resume_pop dut%0d: got %0d required 1", d, pops[d] - p[d]);
            end
        end
        flush();
    endtask

    task automatic test_enable_drop();
        int         nb;
        logic [7:0] b0;
        int         p[2];
        p  = pops;
        b0 = 8'($urandom_range(0, 255));
        push_both(b0);
        push_both(8'($urandom_range(0, 255)));
        enable = 1'b1;
        start_capture();
        steps(10);
        enable = 1'b0;
        steps(70);
        cap_on = 1'b0;
        bytes_q = '{b0};
        for (int d = 0; d < 2; d++) begin
            build_exp(d);
            nb = wave_diff(d, 80);
            checks++;
            if (nb !== 0) begin
                errors++;
                $display("FAIL endrop_wave dut%0d byte %h: %0d bad slots, first %0d tx=%b required %b",
                         d, b0, nb, first_bad, ctx[d][first_bad], etx[d][first_bad]);
            end
            checks++;
            if (pops[d] - p[d] !== 1) begin
                errors++;
                $display("FAIL endrop_pops dut%0d: got %0d required 1", d, pops[d] - p[d]);
            end
        end
        flush();
    endtask

    task automatic test_random_stream();
        int         nb;
        logic [7:0] b;
        int         p[2];
        p = pops;
        bytes_q.delete();
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(0, 255));
            bytes_q.push_back(b);
            push_both(b);
        end
        enable = 1'b1;
        start_capture();
        steps(300);
        cap_on = 1'b0;
        for (int d = 0; d < 2; d++) begin
            build_exp(d);
            nb = wave_diff(d, 300);
            checks++;
            if (nb !== 0) begin
                errors++;
                $display("FAIL stream_wave dut%0d: %0d bad slots, first %0d tx=%b busy=%b rd_en=%b, required tx=%b busy=%b rd_en=%b",
                         d, nb, first_bad, ctx[d][first_bad], cbusy[d][first_bad],
                         crd[d][first_bad], etx[d][first_bad], ebusy[d][first_bad],
                         erd[d][first_bad]);
            end
            checks++;
            if (pops[d] - p[d] !== 5) begin
                errors++;
                $display("FAIL stream_pops dut%0d: got %0d required 5", d, pops[d] - p[d]);
            end
        end
        flush();
    endtask

    initial begin
        pops   = '{0, 0};
        reset  = 1'b1;
        enable = 1'b0;
        steps(3);
        reset = 1'b0;
        step();
        test_reset();
        test_single_byte();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_enable_low();
        test_enable_drop();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
